// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - redirect/stall controls in, registered fetch PC and flags out
interface pc_gen_if;
  logic        stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic [31:0] pre_pc;
  logic [31:0] pre_exception_type;
  logic        redirect_pending;

  modport master (
    input  stall, flush, flush_pc, branch_valid, branch_target,
    output pre_pc, pre_exception_type, redirect_pending
  );

  modport slave (
    output stall, flush, flush_pc, branch_valid, branch_target,
    input  pre_pc, pre_exception_type, redirect_pending
  );
endinterface

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - pre-IF program counter: sequential advance, branch/flush redirects,
// stall-time branch capture and fetch address error flagging
module pc_gen #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter int          ADEL_BIT = 0
) (
  input  logic      clk,
  input  logic      rst,
  pc_gen_if.master  bus
);

  typedef enum logic {NORMAL, PEND_BR} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] exc_q, exc_d;
  logic [31:0] pend_q, pend_d;
  logic        load_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NORMAL;
      pc_q    <= RESET_PC;
      exc_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      exc_q   <= exc_d;
      pend_q  <= pend_d;
    end
  end

  // Priority: flush > stall > fresh branch > pending branch > sequential.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    load_pc = 1'b0;
    if (bus.flush) begin
      pc_d    = bus.flush_pc;
      state_d = NORMAL;
      pend_d  = '0;
      load_pc = 1'b1;
    end else if (bus.stall) begin
      if (bus.branch_valid) begin
        pend_d  = bus.branch_target;
        state_d = PEND_BR;
      end
    end else if (bus.branch_valid) begin
      pc_d    = bus.branch_target;
      state_d = NORMAL;
      load_pc = 1'b1;
    end else if (state_q == PEND_BR) begin
      pc_d    = pend_q;
      state_d = NORMAL;
      load_pc = 1'b1;
    end else begin
      pc_d    = pc_q + 32'd4;
      load_pc = 1'b1;
    end
  end

  // Flags are reloaded together with the PC so they always describe pre_pc.
  always_comb begin
    exc_d = exc_q;
    if (load_pc) begin
      exc_d           = '0;
      exc_d[ADEL_BIT] = (pc_d[1:0] != 2'b00);
    end
  end

  assign bus.pre_pc             = pc_q;
  assign bus.pre_exception_type = exc_q;
  assign bus.redirect_pending   = (state_q == PEND_BR);

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - self-checking bench for pc_gen with directed and random stimulus
module tb_pc_gen;

  localparam logic [31:0] RST_PC = 32'hBFC00000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  // Reference: fetch PC, whether a captured branch is waiting, and its target.
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_tgt;

  pc_gen_if bus ();

  pc_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step();
    if (rst) begin
      m_pc = RST_PC; m_pend = 0; m_tgt = '0;
    end else if (bus.flush) begin
      m_pc = bus.flush_pc; m_pend = 0;
    end else if (bus.stall) begin
      if (bus.branch_valid) begin
        m_pend = 1; m_tgt = bus.branch_target;
      end
    end else if (bus.branch_valid) begin
      m_pc = bus.branch_target; m_pend = 0;
    end else if (m_pend) begin
      m_pc = m_tgt; m_pend = 0;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  function automatic logic [31:0] m_exc();
    return {31'b0, (m_pc[1:0] != 2'b00)};
  endfunction

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall = 0; bus.flush = 0; bus.flush_pc = '0;
    bus.branch_valid = 0; bus.branch_target = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    cycle();
    cycle();
    n_checks++;
    if (bus.pre_pc !== RST_PC) $display("FAIL reset_pc: got %h expected %h", bus.pre_pc, RST_PC);
    else n_pass++;
    n_checks++;
    if (bus.pre_exception_type !== 32'h0) $display("FAIL reset_exc: got %h expected 0", bus.pre_exception_type);
    else n_pass++;
    n_checks++;
    if (bus.redirect_pending !== 1'b0) $display("FAIL reset_pending: got %b expected 0", bus.redirect_pending);
    else n_pass++;
    rst = 0;
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      cycle();
      n_checks++;
      if (bus.pre_pc !== RST_PC + 32'(4 * i) || bus.pre_exception_type !== 32'h0 || bus.redirect_pending !== 1'b0)
        $display("FAIL seq_%0d: got pc=%h exc=%h rp=%b expected pc=%h exc=0 rp=0",
                 i, bus.pre_pc, bus.pre_exception_type, bus.redirect_pending, RST_PC + 32'(4 * i));
      else n_pass++;
    end
  endtask

  task automatic test_branch();
    bus.branch_valid = 1; bus.branch_target = 32'hBFC00100;
    cycle();
    bus.branch_valid = 0;
    n_checks++;
    if (bus.pre_pc !== 32'hBFC00100) $display("FAIL branch_taken: got %h expected BFC00100", bus.pre_pc);
    else n_pass++;
    cycle();
    n_checks++;
    if (bus.pre_pc !== 32'hBFC00104) $display("FAIL branch_next: got %h expected BFC00104", bus.pre_pc);
    else n_pass++;
  endtask

  task automatic test_stall_branch();
    bus.stall = 1; bus.branch_valid = 1; bus.branch_target = 32'hBFC00200;
    cycle();
    bus.branch_valid = 0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.pre_pc !== 32'hBFC00104 || bus.redirect_pending !== 1'b1)
        $display("FAIL stall_hold_%0d: got pc=%h rp=%b expected pc=BFC00104 rp=1", i, bus.pre_pc, bus.redirect_pending);
      else n_pass++;
      if (i < 2) cycle();
    end
    bus.stall = 0;
    cycle();
    n_checks++;
    if (bus.pre_pc !== 32'hBFC00200 || bus.redirect_pending !== 1'b0)
      $display("FAIL stall_release: got pc=%h rp=%b expected pc=BFC00200 rp=0", bus.pre_pc, bus.redirect_pending);
    else n_pass++;
  endtask

  task automatic test_flush_pending();
    bus.stall = 1; bus.branch_valid = 1; bus.branch_target = 32'hBFC00300;
    cycle();
    bus.branch_valid = 0;
    n_checks++;
    if (bus.redirect_pending !== 1'b1) $display("FAIL flush_pre_pending: got %b expected 1", bus.redirect_pending);
    else n_pass++;
    bus.flush = 1; bus.flush_pc = 32'hBFC00380;
    cycle();
    bus.flush = 0;
    n_checks++;
    if (bus.pre_pc !== 32'hBFC00380 || bus.redirect_pending !== 1'b0)
      $display("FAIL flush_over_stall: got pc=%h rp=%b expected pc=BFC00380 rp=0", bus.pre_pc, bus.redirect_pending);
    else n_pass++;
    bus.stall = 0;
    cycle();
    n_checks++;
    if (bus.pre_pc !== 32'hBFC00384) $display("FAIL flush_discards: got %h expected BFC00384", bus.pre_pc);
    else n_pass++;
  endtask

  task automatic test_misaligned();
    bus.branch_valid = 1; bus.branch_target = 32'hBFC00102;
    cycle();
    bus.branch_valid = 0;
    n_checks++;
    if (bus.pre_pc !== 32'hBFC00102 || bus.pre_exception_type !== 32'h1)
      $display("FAIL adel_set: got pc=%h exc=%h expected pc=BFC00102 exc=1", bus.pre_pc, bus.pre_exception_type);
    else n_pass++;
    cycle();
    n_checks++;
    if (bus.pre_pc !== 32'hBFC00106 || bus.pre_exception_type !== 32'h1)
      $display("FAIL adel_sticky: got pc=%h exc=%h expected pc=BFC00106 exc=1", bus.pre_pc, bus.pre_exception_type);
    else n_pass++;
    bus.flush = 1; bus.flush_pc = 32'hBFC00380;
    cycle();
    bus.flush = 0;
    n_checks++;
    if (bus.pre_pc !== 32'hBFC00380 || bus.pre_exception_type !== 32'h0)
      $display("FAIL adel_clear: got pc=%h exc=%h expected pc=BFC00380 exc=0", bus.pre_pc, bus.pre_exception_type);
    else n_pass++;
  endtask

  task automatic test_wrap_reset();
    bus.flush = 1; bus.flush_pc = 32'hFFFFFFFC;
    cycle();
    bus.flush = 0;
    cycle();
    n_checks++;
    if (bus.pre_pc !== 32'h00000000 || bus.pre_exception_type !== 32'h0)
      $display("FAIL wrap: got pc=%h exc=%h expected pc=00000000 exc=0", bus.pre_pc, bus.pre_exception_type);
    else n_pass++;
    bus.stall = 1; bus.branch_valid = 1; bus.branch_target = 32'h12345678;
    cycle();
    bus.branch_valid = 0;
    rst = 1;
    cycle();
    rst = 0; bus.stall = 0;
    n_checks++;
    if (bus.pre_pc !== RST_PC || bus.redirect_pending !== 1'b0)
      $display("FAIL rst_pending: got pc=%h rp=%b expected pc=%h rp=0", bus.pre_pc, bus.redirect_pending, RST_PC);
    else n_pass++;
    cycle();
    n_checks++;
    if (bus.pre_pc !== RST_PC + 32'd4) $display("FAIL rst_discards: got %h expected %h", bus.pre_pc, RST_PC + 32'd4);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst              = ($urandom_range(63) == 0);
      bus.stall        = ($urandom_range(1) == 0);
      bus.flush        = ($urandom_range(15) == 0);
      bus.flush_pc     = $urandom() & (($urandom_range(7) == 0) ? 32'hFFFFFFFF : 32'hFFFFFFFC);
      bus.branch_valid = ($urandom_range(3) == 0);
      bus.branch_target = $urandom() & (($urandom_range(7) == 0) ? 32'hFFFFFFFF : 32'hFFFFFFFC);
      cycle();
      n_checks++;
      if (bus.pre_pc !== m_pc || bus.pre_exception_type !== m_exc() || bus.redirect_pending !== m_pend)
        $display("FAIL random_%0d: got pc=%h exc=%h rp=%b expected pc=%h exc=%h rp=%b",
                 i, bus.pre_pc, bus.pre_exception_type, bus.redirect_pending, m_pc, m_exc(), m_pend);
      else n_pass++;
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1;
    m_pc     = RST_PC;
    m_pend   = 0;
    m_tgt    = '0;
    idle_inputs();
    test_reset();
    test_sequential();
    test_branch();
    test_stall_branch();
    test_flush_pending();
    test_misaligned();
    test_wrap_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Pre-IF program-counter generator. It is the producer side of the pre-IF -> IF pipeline register: it drives pre_pc and pre_exception_type into that register.
- Holds the fetch PC and advances it sequentially by 4.
- Applies branch redirects from ID and exception/ERET redirects from the exception unit.
- Buffers a branch redirect that arrives during a stall, and flags misaligned fetch addresses as an instruction address error.

Parameters:
- RESET_PC, 32'hBFC00000, PC loaded on reset.
- ADEL_BIT, 0, bit index in pre_exception_type flagging a fetch address error.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- stall  input  1  pipeline stall from hazard/SRAM logic; 1 = hold PC
- flush  input  1  exception or ERET redirect; overrides stall
- flush_pc  input  32  redirect target, valid when flush=1 (exception vector or EPC)
- branch_valid  input  1  one-cycle pulse from ID: taken branch or jump
- branch_target  input  32  branch/jump target, valid with branch_valid
- pre_pc  output  32  registered fetch PC to the pre-IF/IF register
- pre_exception_type  output  32  registered exception flags matching pre_pc
- redirect_pending  output  1  1 while a captured branch target awaits release of stall

Behaviour:
- Synchronous, active-high rst. Reset state:
  - pre_pc = RESET_PC
  - pre_exception_type = 0
  - state = NORMAL; redirect_pending = 0
  - pend_target = 0
- rst mid-operation discards any pending redirect.
- State machine: NORMAL, PEND_BR. redirect_pending = (state == PEND_BR).
- Per-cycle priority: rst > flush > stall > branch_valid > PEND_BR > sequential.
- flush=1:
  - next_pc = flush_pc.
  - state -> NORMAL; pending target discarded.
  - Applies regardless of stall or branch_valid.
- stall=1, flush=0:
  - pre_pc and pre_exception_type hold.
  - If branch_valid: pend_target <= branch_target; state -> PEND_BR.
  - A second branch_valid while in PEND_BR overwrites pend_target (latest wins).
- stall=0, flush=0:
  - branch_valid=1: next_pc = branch_target; state -> NORMAL. This is the same-cycle pulse winning over an older pending target.
  - else if PEND_BR: next_pc = pend_target; state -> NORMAL.
  - else: next_pc = pre_pc + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
- Latency: every redirect is visible on pre_pc exactly one cycle after it is accepted. Stalled cycles add one cycle each before a pending target is applied.
- Exception flags:
  - Loaded in the same cycle as next_pc.
  - pre_exception_type[ADEL_BIT] = (next_pc[1:0] != 2'b00); all other bits 0.
  - A misaligned PC keeps advancing by 4, so the flag stays set until a flush redirects to an aligned address.
- No combinational path from any input to any output.

Test Plan:
- Reset, then 3 cycles with stall=0 -> pre_pc 0xBFC00000, 0xBFC00004, 0xBFC00008, 0xBFC0000C; pre_exception_type=0; redirect_pending=0.
- branch_valid pulse with target 0xBFC00100, stall=0 -> next cycle pre_pc=0xBFC00100, then 0xBFC00104.
- stall=1 for 3 cycles with branch_valid pulse (target 0xBFC00200) in the first:
  - pre_pc holds; redirect_pending=1 from the cycle after the pulse.
  - First cycle with stall=0 -> pre_pc=0xBFC00200, redirect_pending=0.
- While PEND_BR and stall=1, assert flush with flush_pc=0xBFC00380 -> next cycle pre_pc=0xBFC00380, redirect_pending=0; the pending target is never applied.
- Branch to 0xBFC00102 -> pre_pc=0xBFC00102, pre_exception_type=0x00000001, next 0xBFC00106 still flagged. flush_pc=0xBFC00380 -> flag clears to 0.
- Wrap and reset:
  - flush_pc=0xFFFFFFFC -> next pre_pc=0x00000000, flag 0.
  - rst asserted while PEND_BR -> pre_pc=0xBFC00000, redirect_pending=0; pending target never appears after reset.
